// File: rtl/debug_seq.sv
// Debug command sequencer: turns host READ/WRITE/RUN/STOP/STEP/DUMP/STATUS commands
// into cycles on a combinational per-core debug mux port and returns response beats.
`ifndef LOG_CORES
`define LOG_CORES 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module debug_seq #(
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2:0]             cmd_op,
   input  logic [`LOG_CORES-1:0]  cmd_core,
   input  logic [3:0]             cmd_reg,
   input  logic [`DATA_WIDTH-1:0] cmd_data,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [`DATA_WIDTH-1:0] rsp_data,
   output logic                   rsp_last,
   output logic                   rsp_err,
   output logic [`LOG_CORES-1:0]  dbg_sel,
   output logic [4:0]             dbg_addr,
   output logic                   dbg_we,
   output logic [`DATA_WIDTH-1:0] dbg_wdata,
   input  logic [`DATA_WIDTH-1:0] dbg_rdata,
   output logic                   busy
);
   localparam int DW = `DATA_WIDTH;
   localparam int CW = `LOG_CORES;
   localparam int PW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [2:0] OP_READ = 3'd0, OP_WRITE = 3'd1, OP_RUN = 3'd2, OP_STOP = 3'd3,
                          OP_STEP = 3'd4, OP_DUMP = 3'd5, OP_STATUS = 3'd6;
   localparam logic [4:0]    MODE_ADDR = 5'b10000;
   localparam logic [DW-1:0] MODE_STOP = DW'(1), MODE_RUN = DW'(2), MODE_STEP = DW'(3);

   typedef enum logic [2:0] {IDLE, CHECK, ACCESS, STEP_PULSE, STEP_WAIT, RESP} state_t;

   state_t        state, state_d;
   logic [2:0]    op_q, op_d;
   logic [CW-1:0] core_q, core_d;
   logic [3:0]    reg_q, reg_d;
   logic [DW-1:0] data_q, data_d, rem_q, rem_d, done_q, done_d, rdata_q, rdata_d;
   logic [PW-1:0] poll_q, poll_d;
   logic          err_q, err_d, last_q, last_d;
   logic          stopped;

   // Status reads go through the combinational mux, so the flag is valid this cycle.
   assign stopped   = dbg_rdata[0];
   assign cmd_ready = (state == IDLE) && !rst;
   assign rsp_valid = (state == RESP);
   assign rsp_data  = rsp_valid ? rdata_q : '0;
   assign rsp_last  = rsp_valid && last_q;
   assign rsp_err   = rsp_valid && err_q;
   assign busy      = (state != IDLE);

   always_comb begin
      state_d = state;
      op_d    = op_q;
      core_d  = core_q;
      reg_d   = reg_q;
      data_d  = data_q;
      rem_d   = rem_q;
      done_d  = done_q;
      poll_d  = poll_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      last_d  = last_q;
      case (state)
         IDLE: if (cmd_valid && cmd_ready) begin
            op_d    = cmd_op;
            core_d  = cmd_core;
            reg_d   = (cmd_op == OP_DUMP) ? 4'd0 : cmd_reg;
            data_d  = cmd_data;
            rem_d   = cmd_data;
            done_d  = '0;
            poll_d  = '0;
            rdata_d = '0;
            err_d   = 1'b0;
            last_d  = 1'b1;
            case (cmd_op)
               OP_RUN, OP_STOP: state_d = ACCESS;
               3'd7: begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
               OP_STEP: state_d = (cmd_data == '0) ? RESP : CHECK;
               default: state_d = CHECK;
            endcase
         end
         CHECK: begin
            if (op_q == OP_STATUS) begin
               rdata_d = {{(DW-1){1'b0}}, stopped};
               state_d = RESP;
            end else if (!stopped) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               state_d = (op_q == OP_STEP) ? STEP_PULSE : ACCESS;
            end
         end
         ACCESS: begin
            case (op_q)
               OP_READ:  rdata_d = dbg_rdata;
               OP_DUMP: begin
                  rdata_d = dbg_rdata;
                  last_d  = (reg_q == 4'd15);
               end
               OP_WRITE: rdata_d = data_q;
               default:  rdata_d = '0;
            endcase
            state_d = RESP;
         end
         STEP_PULSE: begin
            poll_d  = '0;
            state_d = STEP_WAIT;
         end
         STEP_WAIT: begin
            if (stopped) begin
               rem_d  = rem_q - DW'(1);
               done_d = done_q + DW'(1);
               if (rem_q == DW'(1)) begin
                  rdata_d = data_q;
                  state_d = RESP;
               end else begin
                  state_d = STEP_PULSE;
               end
            end else if (poll_q == PW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               rdata_d = done_q;
               state_d = RESP;
            end else begin
               poll_d = poll_q + PW'(1);
            end
         end
         RESP: if (rsp_ready) begin
            if (op_q == OP_DUMP && !last_q) begin
               reg_d   = reg_q + 4'd1;
               state_d = ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dbg_sel   = '0;
      dbg_addr  = '0;
      dbg_we    = 1'b0;
      dbg_wdata = '0;
      case (state)
         CHECK, STEP_WAIT: begin
            dbg_sel  = core_q;
            dbg_addr = MODE_ADDR;
         end
         STEP_PULSE: begin
            dbg_sel   = core_q;
            dbg_addr  = MODE_ADDR;
            dbg_we    = 1'b1;
            dbg_wdata = MODE_STEP;
         end
         ACCESS: begin
            dbg_sel = core_q;
            case (op_q)
               OP_RUN, OP_STOP: begin
                  dbg_addr  = MODE_ADDR;
                  dbg_we    = 1'b1;
                  dbg_wdata = (op_q == OP_RUN) ? MODE_RUN : MODE_STOP;
               end
               OP_WRITE: begin
                  dbg_addr  = {1'b0, reg_q};
                  dbg_we    = 1'b1;
                  dbg_wdata = data_q;
               end
               default: dbg_addr = {1'b0, reg_q};
            endcase
         end
         default: ;
      endcase
      // A reset arriving mid-operation must not let a write slip out this cycle.
      if (rst) dbg_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= '0;
         core_q  <= '0;
         reg_q   <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         done_q  <= '0;
         poll_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state   <= state_d;
         op_q    <= op_d;
         core_q  <= core_d;
         reg_q   <= reg_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         poll_q  <= poll_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         last_q  <= last_d;
      end
   end
endmodule

// File: tb/tb_debug_seq.sv
// Scoreboard bench for debug_seq with a behavioural multi-core debug target model.
`ifndef LOG_CORES
`define LOG_CORES 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_debug_seq;
   localparam int DW = `DATA_WIDTH;
   localparam int CW = `LOG_CORES;
   localparam int NC = 1 << CW;
   localparam int TO = 8;
   localparam logic [2:0] OP_READ = 3'd0, OP_WRITE = 3'd1, OP_RUN = 3'd2, OP_STOP = 3'd3,
                          OP_STEP = 3'd4, OP_DUMP = 3'd5, OP_STATUS = 3'd6, OP_BAD = 3'd7;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          err;
   } exp_t;

   logic          clk = 1'b0, rst = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready;
   logic [2:0]    cmd_op = '0;
   logic [CW-1:0] cmd_core = '0;
   logic [3:0]    cmd_reg = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_last, rsp_err, dbg_we, busy;
   logic [DW-1:0] rsp_data, dbg_wdata, dbg_rdata;
   logic [CW-1:0] dbg_sel;
   logic [4:0]    dbg_addr;

   exp_t exp_q[$];
   int   n_chk = 0, n_fail = 0;

   // Target model: per-core register file plus stopped flag; a step pulse clears
   // the flag and re-sets it step_delay cycles later (never when negative).
   logic [DW-1:0] regs [NC][16];
   logic [NC-1:0] stopped;
   int            restop [NC];
   int            step_delay = -1;
   logic          model_load = 1'b0;
   logic [NC-1:0] init_mask = '0;
   int            pulse_cnt = 0, lo_we_cnt = 0, we_cnt = 0, status_cnt = 0, act_cnt = 0;

   always #5 clk = ~clk;

   debug_seq #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_core(cmd_core), .cmd_reg(cmd_reg), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .busy(busy));

   function automatic logic [DW-1:0] pat(int c, int i);
      return DW'(32'hA000 + c * 256 + i * 17);
   endfunction

   function automatic exp_t mk(logic [DW-1:0] d, logic l, logic e);
      exp_t r;
      r.data = d;
      r.last = l;
      r.err  = e;
      return r;
   endfunction

   assign dbg_rdata = dbg_addr[4] ? {{(DW-1){1'b0}}, stopped[dbg_sel]} : regs[dbg_sel][dbg_addr[3:0]];

   always @(posedge clk) begin
      if (model_load) begin
         for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < 16; i++) regs[c][i] <= pat(c, i);
            restop[c] <= 0;
         end
         stopped <= init_mask;
      end else begin
         for (int c = 0; c < NC; c++)
            if (restop[c] > 0) begin
               restop[c] <= restop[c] - 1;
               if (restop[c] == 1) stopped[c] <= 1'b1;
            end
         if (dbg_we) begin
            if (dbg_addr[4]) begin
               case (dbg_wdata[1:0])
                  2'b01: stopped[dbg_sel] <= 1'b1;
                  2'b10: begin stopped[dbg_sel] <= 1'b0; restop[dbg_sel] <= 0; end
                  2'b11: begin
                     stopped[dbg_sel] <= 1'b0;
                     restop[dbg_sel]  <= (step_delay < 0) ? 0 : step_delay;
                  end
                  default: ;
               endcase
            end else begin
               regs[dbg_sel][dbg_addr[3:0]] <= dbg_wdata;
            end
         end
      end
      if (dbg_we) we_cnt <= we_cnt + 1;
      if (dbg_we && !dbg_addr[4]) lo_we_cnt <= lo_we_cnt + 1;
      if (dbg_we && dbg_addr == 5'h10 && dbg_wdata[1:0] == 2'b11) pulse_cnt <= pulse_cnt + 1;
      if (!dbg_we && dbg_addr == 5'h10) status_cnt <= status_cnt + 1;
      if (dbg_we || dbg_addr != '0 || dbg_sel != '0) act_cnt <= act_cnt + 1;
   end

   task automatic model_setup(input logic [NC-1:0] mask, input int delay);
      @(negedge clk);
      init_mask  = mask;
      step_delay = delay;
      model_load = 1'b1;
      @(negedge clk);
      model_load = 1'b0;
   endtask

   task automatic send_cmd(input logic [2:0] op, input int core, input int rg,
                           input logic [DW-1:0] d, output bit ok);
      ok = 0;
      @(negedge clk);
      cmd_op    = op;
      cmd_core  = CW'(core);
      cmd_reg   = 4'(rg);
      cmd_data  = d;
      cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic get_beat(input bit toggle, output exp_t got, output logic rdy_hs, output bit ok);
      ok     = 0;
      got    = '0;
      rdy_hs = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         rsp_ready = toggle ? ~rsp_ready : 1'b1;
         if (rsp_valid && rsp_ready) begin
            got    = mk(rsp_data, rsp_last, rsp_err);
            rdy_hs = cmd_ready;
            ok     = 1;
            break;
         end
      end
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic run_cmd(input logic [2:0] op, input int core, input int rg, input logic [DW-1:0] d,
                          input exp_t expv, output exp_t got, output exp_t want, output bit ok);
      bit   ok1, ok2;
      logic r;
      exp_q.push_back(expv);
      send_cmd(op, core, rg, d, ok1);
      get_beat(0, got, r, ok2);
      want = exp_q.pop_front();
      ok   = ok1 && ok2;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_chk++;
      if ({cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_err, dbg_sel, dbg_addr, dbg_we, dbg_wdata, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b valid=%b data=%h sel=%h addr=%h we=%b busy=%b, all required 0",
                  cmd_ready, rsp_valid, rsp_data, dbg_sel, dbg_addr, dbg_we, busy);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
      end
   endtask

   task automatic test_write_read();
      exp_t got, want;
      bit   ok;
      int   lat;
      model_setup(4'b1101, -1);
      run_cmd(OP_WRITE, 2, 5, DW'(16'h1234), mk(DW'(16'h1234), 1'b1, 1'b0), got, want, ok);
      n_chk++;
      if (!ok || got !== want) begin
         n_fail++;
         $display("FAIL write_rsp: got %h required %h (ok=%0d)", got, want, ok);
      end
      exp_q.push_back(mk(DW'(16'h1234), 1'b1, 1'b0));
      send_cmd(OP_READ, 2, 5, '0, ok);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 lat++;
         if (rsp_valid) break;
      end
      n_chk++;
      if (!ok || lat != 2) begin
         n_fail++;
         $display("FAIL read_latency: got %0d cycles required 2 (ok=%0d)", lat, ok);
      end
      begin
         logic r;
         get_beat(0, got, r, ok);
      end
      want = exp_q.pop_front();
      n_chk++;
      if (!ok || got !== want) begin
         n_fail++;
         $display("FAIL read_rsp: got %h required %h", got, want);
      end
      run_cmd(OP_READ, 0, 9, '0, mk(pat(0, 9), 1'b1, 1'b0), got, want, ok);
      n_chk++;
      if (!ok || got !== want) begin
         n_fail++;
         $display("FAIL read_untouched: got %h required %h", got, want);
      end
   endtask

   task automatic test_write_running();
      exp_t got, want;
      bit   ok;
      int   base;
      base = lo_we_cnt;
      run_cmd(OP_WRITE, 1, 3, DW'(16'h5A5A), mk('0, 1'b1, 1'b1), got, want, ok);
      n_chk++;
      if (!ok || got !== want) begin
         n_fail++;
         $display("FAIL write_running_rsp: got %h required %h", got, want);
      end
      n_chk++;
      if (lo_we_cnt != base || regs[1][3] !== pat(1, 3)) begin
         n_fail++;
         $display("FAIL write_running_we: reg writes %0d reg=%h, required 0 and %h", lo_we_cnt - base, regs[1][3], pat(1, 3));
      end
   endtask

   task automatic test_run_stop();
      exp_t got, want;
      bit   ok;
      run_cmd(OP_STOP, 1, 0, '0, mk('0, 1'b1, 1'b0), got, want, ok);
      n_chk++;
      if (!ok || got !== want || stopped[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL stop_cmd: got %h stopped=%b required %h stopped=1", got, stopped[1], want);
      end
      run_cmd(OP_STATUS, 1, 0, '0, mk(DW'(1), 1'b1, 1'b0), got, want, ok);
      n_chk++;
      if (!ok || got !== want) begin
         n_fail++;
         $display("FAIL status_stopped: got %h required %h", got, want);
      end
      run_cmd(OP_RUN, 1, 0, '0, mk('0, 1'b1, 1'b0), got, want, ok);
      n_chk++;
      if (!ok || got !== want || stopped[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL run_cmd: got %h stopped=%b required %h stopped=0", got, stopped[1], want);
      end
      run_cmd(OP_STATUS, 1, 0, '0, mk('0, 1'b1, 1'b0), got, want, ok);
      n_chk++;
      if (!ok || got !== want) begin
         n_fail++;
         $display("FAIL status_running: got %h required %h", got, want);
      end
   endtask

   task automatic test_step();
      exp_t got, want;
      bit   ok;
      int   base;
      model_setup('1, 2);
      base = pulse_cnt;
      run_cmd(OP_STEP, 0, 0, DW'(3), mk(DW'(3), 1'b1, 1'b0), got, want, ok);
      n_chk++;
      if (!ok || got !== want) begin
         n_fail++;
         $display("FAIL step3_rsp: got %h required %h", got, want);
      end
      n_chk++;
      if (pulse_cnt - base != 3) begin
         n_fail++;
         $display("FAIL step3_pulses: got %0d required 3", pulse_cnt - base);
      end
      base = pulse_cnt;
      run_cmd(OP_STEP, 0, 0, '0, mk('0, 1'b1, 1'b0), got, want, ok);
      n_chk++;
      if (!ok || got !== want || pulse_cnt != base) begin
         n_fail++;
         $display("FAIL step0: got %h pulses %0d required %h pulses 0", got, pulse_cnt - base, want);
      end
   endtask

   task automatic test_step_timeout();
      exp_t got, want;
      bit   ok;
      int   bp, bs;
      model_setup('1, -1);
      bp = pulse_cnt;
      bs = status_cnt;
      run_cmd(OP_STEP, 0, 0, DW'(2), mk('0, 1'b1, 1'b1), got, want, ok);
      n_chk++;
      if (!ok || got !== want) begin
         n_fail++;
         $display("FAIL step_timeout_rsp: got %h required %h", got, want);
      end
      n_chk++;
      if (pulse_cnt - bp != 1 || status_cnt - bs != 1 + TO) begin
         n_fail++;
         $display("FAIL step_timeout_polls: pulses %0d status reads %0d required 1 and %0d",
                  pulse_cnt - bp, status_cnt - bs, 1 + TO);
      end
   endtask

   task automatic test_illegal();
      exp_t got, want;
      bit   ok;
      int   base;
      base = act_cnt;
      run_cmd(OP_BAD, 3, 7, DW'(16'hFFFF), mk('0, 1'b1, 1'b1), got, want, ok);
      n_chk++;
      if (!ok || got !== want || act_cnt != base) begin
         n_fail++;
         $display("FAIL illegal_op: got %h port activity %0d required %h activity 0", got, act_cnt - base, want);
      end
   endtask

   task automatic test_dump();
      exp_t          got, want;
      bit            ok, stalled;
      logic [DW-1:0] held;
      int            beats, bad_stable;
      model_setup('1, -1);
      for (int i = 0; i < 16; i++) exp_q.push_back(mk(pat(3, i), i == 15, 1'b0));
      send_cmd(OP_DUMP, 3, 0, '0, ok);
      beats = 0;
      bad_stable = 0;
      stalled = 0;
      held = '0;
      for (int i = 0; i < 300 && beats < 16; i++) begin
         @(negedge clk);
         rsp_ready = ~rsp_ready;
         if (rsp_valid) begin
            if (stalled && rsp_data !== held) bad_stable++;
            if (rsp_ready) begin
               got  = mk(rsp_data, rsp_last, rsp_err);
               want = exp_q.pop_front();
               beats++;
               stalled = 0;
               n_chk++;
               if (got !== want) begin
                  n_fail++;
                  $display("FAIL dump_beat%0d: got %h required %h", beats, got, want);
               end
            end else begin
               stalled = 1;
               held = rsp_data;
            end
         end
      end
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      repeat (4) @(negedge clk);
      n_chk++;
      if (!ok || beats != 16 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL dump_count: beats %0d valid=%b busy=%b required 16/0/0", beats, rsp_valid, busy);
      end
      n_chk++;
      if (bad_stable != 0) begin
         n_fail++;
         $display("FAIL dump_stall_stable: %0d changes while stalled, required 0", bad_stable);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_dump();
      exp_t got, want;
      bit   ok;
      logic r;
      int   base, vcnt;
      send_cmd(OP_DUMP, 3, 0, '0, ok);
      for (int i = 0; i < 7; i++) begin
         get_beat(0, got, r, ok);
         n_chk++;
         if (!ok || got !== mk(pat(3, i), 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL rdump_beat%0d: got %h required %h", i, got, mk(pat(3, i), 1'b0, 1'b0));
         end
      end
      @(negedge clk);
      rst  = 1'b1;
      base = we_cnt;
      @(negedge clk);
      n_chk++;
      if ({cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_err, dbg_sel, dbg_addr, dbg_we, dbg_wdata, busy} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: valid=%b data=%h sel=%h addr=%h we=%b busy=%b, all required 0",
                  rsp_valid, rsp_data, dbg_sel, dbg_addr, dbg_we, busy);
      end
      rst  = 1'b0;
      vcnt = 0;
      rsp_ready = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid) vcnt++;
      end
      rsp_ready = 1'b0;
      n_chk++;
      if (vcnt != 0 || we_cnt != base) begin
         n_fail++;
         $display("FAIL mid_reset_quiet: beats %0d writes %0d required 0 and 0", vcnt, we_cnt - base);
      end
      run_cmd(OP_READ, 3, 2, '0, mk(pat(3, 2), 1'b1, 1'b0), got, want, ok);
      n_chk++;
      if (!ok || got !== want) begin
         n_fail++;
         $display("FAIL read_after_reset: got %h required %h", got, want);
      end
   endtask

   task automatic test_back_to_back();
      exp_t got;
      bit   ok1, ok2;
      logic r;
      for (int k = 0; k < 2; k++) begin
         send_cmd(OP_READ, 0, 10 + k, '0, ok1);
         get_beat(0, got, r, ok2);
         n_chk++;
         if (!ok1 || !ok2 || got !== mk(pat(0, 10 + k), 1'b1, 1'b0) || r !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back%0d: got %h cmd_ready_at_accept=%b required %h and 0",
                     k, got, r, mk(pat(0, 10 + k), 1'b1, 1'b0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_write_running();
      test_run_stop();
      test_step();
      test_step_timeout();
      test_illegal();
      test_dump();
      test_reset_mid_dump();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/debug_seq.md
DEBUG_SEQ -- requirements
Module: debug_seq

Interface
REQ-001 SHALL take widths from the global macros: `LOG_CORES (core index width) and `DATA_WIDTH (data width); parameter TIMEOUT, default 255, is the max poll cycles per step.
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports: clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-003 SHALL have cmd_valid in 1 and cmd_ready out 1 (command handshake), cmd_op in 3 (opcode), cmd_core in `LOG_CORES (target core).
REQ-004 SHALL have cmd_reg in 4 (register index) and cmd_data in `DATA_WIDTH (write data, or step count).
REQ-005 SHALL have rsp_valid out 1 and rsp_ready in 1 (response handshake), rsp_data out `DATA_WIDTH, rsp_last out 1 (final beat), rsp_err out 1 (error flag).
REQ-006 SHALL have dbg_sel out `LOG_CORES, dbg_addr out 5, dbg_we out 1, dbg_wdata out `DATA_WIDTH and dbg_rdata in `DATA_WIDTH (combinational debug mux port); busy out 1 (not IDLE).

Function
REQ-007 SHALL decode cmd_op as: 0 READ, 1 WRITE, 2 RUN, 3 STOP, 4 STEP, 5 DUMP, 6 STATUS; 7 is illegal.
REQ-008 SHALL encode cpu_mode writes as: 01 stop, 10 run, 11 step, 00 no-op; a mode write is dbg_addr=5'b10000, dbg_we=1, dbg_wdata[1:0]=mode.
REQ-009 SHALL use status read dbg_addr=5'b10000, dbg_we=0; stopped flag = dbg_rdata[0], sampled in the same cycle because the mux path is combinational.
REQ-010 SHALL use states IDLE, CHECK, ACCESS, STEP_PULSE, STEP_WAIT, RESP.
REQ-011 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, latch op/core/reg/data and go to CHECK, except RUN/STOP, which go to ACCESS.
REQ-012 SHALL perform CHECK in 1 cycle: status read. If stopped=0 for READ/WRITE/DUMP/STEP, go to RESP with rsp_err=1 and rsp_data=0. Otherwise READ/WRITE/DUMP go to ACCESS and STEP goes to STEP_PULSE; STATUS goes to RESP with rsp_data={0..,stopped}.
REQ-013 SHALL access in ACCESS for 1 cycle per register. READ uses dbg_addr={0,reg}, we=0, captures dbg_rdata. WRITE uses we=1, wdata=cmd_data, rsp_data=cmd_data. RUN/STOP issue a mode write with rsp_data=0.
REQ-014 SHALL handle DUMP by iterating reg index 0..15. Each index is read in ACCESS and returned via RESP, with rsp_last=1 only on index 15; after each non-last beat is accepted, return to ACCESS with index+1.
REQ-015 SHALL handle STEP with count N=cmd_data. N=0 goes straight to RESP with rsp_data=0. Otherwise STEP_PULSE issues a mode-11 write for exactly 1 cycle, then STEP_WAIT polls status every cycle from the next cycle.
REQ-016 SHALL, in STEP_WAIT, do the following when stopped=1: decrement remaining; if remaining is now 0, go to RESP with rsp_data=N; else go to STEP_PULSE.
REQ-017 SHALL count poll cycles in STEP_WAIT with a counter that resets on each entry. If it reaches TIMEOUT without seeing stopped=1, go to RESP with rsp_err=1 and rsp_data=steps completed so far.
REQ-018 SHALL hold rsp_valid=1 in RESP with data stable until rsp_ready; on acceptance go to IDLE (or back to ACCESS for a non-last DUMP beat). rsp_last=1 for every non-DUMP response.
REQ-019 SHALL drive dbg_we=0 in every state except the ACCESS write cycles and STEP_PULSE. In IDLE and RESP, dbg_sel, dbg_addr and dbg_wdata=0.
REQ-020 SHALL answer an illegal opcode with a single RESP beat, rsp_err=1, rsp_data=0, and no debug port activity.
REQ-021 SHALL not assert cmd_ready in the same cycle that a response is accepted; the next command is accepted at the earliest 1 cycle after returning to IDLE.

Reset
REQ-022 SHALL, while rst=1, enter IDLE. Reset values: cmd_ready=0 during reset then 1 the cycle after rst deasserts; rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, busy=0; dbg_sel=0, dbg_addr=0, dbg_we=0, dbg_wdata=0; all counters 0.
REQ-023 SHALL, on reset mid-operation (including mid-STEP or mid-DUMP), abandon the operation without issuing any further debug write, and drop any pending response.

Verification
REQ-024 Stopped core 2, READ reg 5 with dbg_rdata=0x1234 -> one beat with rsp_data=0x1234, rsp_last=1, rsp_err=0; 2 cycles from command acceptance to rsp_valid.
REQ-025 Running core (stopped=0), WRITE reg 3 -> rsp_err=1, and dbg_we is never asserted with dbg_addr[4]=0.
REQ-026 STEP N=3 with the model re-asserting stopped 2 cycles after each pulse -> exactly three mode-11 write cycles, then rsp_data=3, rsp_err=0.
REQ-027 STEP N=2 with the model never stopping after the first pulse, TIMEOUT=8 -> rsp_err=1, rsp_data=0 after 8 poll cycles.
REQ-028 DUMP with rsp_ready toggled every other cycle -> 16 beats with rsp_data equal to regs 0..15 in order, rsp_last only on beat 16, data stable while stalled.
REQ-029 rst pulsed mid-DUMP at beat 7 -> all outputs at reset values the next cycle, no further beats, and a new READ after reset completes normally.
